// File: rtl/fir_pkg.sv
// Shared defaults and state encoding for the FIR MAC sequencer.
package fir_pkg;

  localparam int NUM_TAP_DEF    = 40;
  localparam int DATA_WIDTH_DEF = 3;
  localparam int WIDTH_DEF      = 16;
  localparam int OUT_WIDTH_DEF  = 25;
  localparam int ADDR_WIDTH_DEF = 6;
  localparam int SAT_WIDTH_DEF  = 16;

  // Saturation limits for the default target width
  localparam longint SAT_MAX_DEF = (longint'(1) <<< (SAT_WIDTH_DEF - 1)) - 1;
  localparam longint SAT_MIN_DEF = -SAT_MAX_DEF - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    MAC     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample / coefficient-memory / MAC signal bundle around the FIR MAC sequencer.
interface fir_mac_sequencer_if #(
  parameter int DATA_WIDTH = 3,
  parameter int WIDTH      = 16,
  parameter int OUT_WIDTH  = 25,
  parameter int ADDR_WIDTH = 6
);
  logic                         iEnSample;
  logic signed [DATA_WIDTH-1:0] iFirIn;
  logic        [ADDR_WIDTH-1:0] oCoeffAddr;
  logic signed [WIDTH-1:0]      iCoeffData;
  logic signed [DATA_WIDTH-1:0] oDelay;
  logic signed [WIDTH-1:0]      oCoeff;
  logic                         oEnMul;
  logic                         oEnAdd;
  logic                         oEnAcc;
  logic signed [OUT_WIDTH-1:0]  iMac;
  logic signed [OUT_WIDTH-1:0]  oFirOut;
  logic                         oFirValid;
  logic                         oBusy;
  logic                         oOverrun;

  modport slave (
    input  iEnSample, iFirIn, iCoeffData, iMac,
    output oCoeffAddr, oDelay, oCoeff, oEnMul, oEnAdd, oEnAcc,
           oFirOut, oFirValid, oBusy, oOverrun
  );

  modport master (
    output iEnSample, iFirIn, iCoeffData, iMac,
    input  oCoeffAddr, oDelay, oCoeff, oEnMul, oEnAdd, oEnAcc,
           oFirOut, oFirValid, oBusy, oOverrun
  );
endinterface

// File: rtl/fir_delay_line.sv
// NUM_TAP-deep sample shift register with a tap-index read mux.
module fir_delay_line #(
  parameter int NUM_TAP    = 40,
  parameter int DATA_WIDTH = 3,
  parameter int IDX_W      = 6
) (
  input  logic                         iClk12M,
  input  logic                         iRst,
  input  logic                         shift_en,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic        [IDX_W-1:0]      idx,
  output logic signed [DATA_WIDTH-1:0] dout
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TAP - 1);

  logic signed [DATA_WIDTH-1:0] d [NUM_TAP];

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      for (int k = 0; k < NUM_TAP; k++) d[k] <= '0;
    end else if (shift_en) begin
      d[0] <= din;
      for (int k = 1; k < NUM_TAP; k++) d[k] <= d[k-1];
    end
  end

  // Out-of-range indices (only possible when NUM_TAP is not a power of two) read as zero
  always_comb begin
    dout = '0;
    if (idx <= LAST) dout = d[idx];
  end
endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences the FIR MAC over NUM_TAP taps per input sample and captures the result.
// Build option: FIR_OUT_SAT_EN clamps the captured result to SAT_WIDTH signed range.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int NUM_TAP    = NUM_TAP_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SAT_WIDTH  = SAT_WIDTH_DEF
) (
  input logic                iClk12M,
  input logic                iRst,
  fir_mac_sequencer_if.slave bus
);
  localparam int               TAP_W    = $clog2(NUM_TAP);
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAP - 1);

  state_t                       state, state_nxt;
  logic        [TAP_W-1:0]      tap;
  logic                         shift_en;
  logic                         overrun_set;
  logic signed [DATA_WIDTH-1:0] tap_data;
  logic signed [OUT_WIDTH-1:0]  cap_val;

  function automatic logic signed [OUT_WIDTH-1:0] sat_clamp(
    input logic signed [OUT_WIDTH-1:0] v
  );
    longint hi, lo, x;
    hi = (longint'(1) <<< (SAT_WIDTH - 1)) - 1;
    lo = -hi - 1;
    x  = longint'(v);
    if (x > hi) x = hi;
    if (x < lo) x = lo;
    return OUT_WIDTH'(x);
  endfunction

  fir_delay_line #(
    .NUM_TAP   (NUM_TAP),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (TAP_W)
  ) u_delay (
    .iClk12M (iClk12M),
    .iRst    (iRst),
    .shift_en(shift_en),
    .din     (bus.iFirIn),
    .idx     (tap),
    .dout    (tap_data)
  );

`ifdef FIR_OUT_SAT_EN
  assign cap_val = sat_clamp(bus.iMac);
`else
  assign cap_val = bus.iMac;
`endif

  assign bus.oCoeff = bus.iCoeffData;

  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    shift_en    = 1'b0;
    overrun_set = 1'b0;
    bus.oEnMul  = 1'b0;
    bus.oEnAdd  = 1'b0;
    bus.oEnAcc  = 1'b0;
    bus.oDelay  = '0;
    bus.oBusy   = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.iEnSample) begin
          shift_en  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = MAC;
      MAC: begin
        bus.oEnMul = 1'b1;
        bus.oEnAdd = (tap == '0);
        bus.oEnAcc = (tap != '0);
        bus.oDelay = tap_data;
        if (tap == LAST_TAP) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Samples arriving mid-sequence (CAPTURE included) are dropped and flagged
    if (bus.iEnSample && state != IDLE) overrun_set = 1'b1;
  end

  // Address/tap counters, output capture and sticky overrun
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      bus.oCoeffAddr <= '0;
      tap            <= '0;
      bus.oFirOut    <= '0;
      bus.oFirValid  <= 1'b0;
      bus.oOverrun   <= 1'b0;
    end else begin
      bus.oFirValid <= 1'b0;
      bus.oOverrun  <= bus.oOverrun | overrun_set;
      case (state)
        IDLE: begin
          if (bus.iEnSample) bus.oCoeffAddr <= '0;
        end
        FETCH: begin
          bus.oCoeffAddr <= ADDR_WIDTH'(1);
          tap            <= '0;
        end
        MAC: begin
          // Prefetch two ahead: memory latency is one cycle and the address is registered
          bus.oCoeffAddr <= ADDR_WIDTH'(tap) + ADDR_WIDTH'(2);
          tap            <= tap + TAP_W'(1);
        end
        CAPTURE: begin
          bus.oFirOut   <= cap_val;
          bus.oFirValid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench: coefficient ROM and MAC models around fir_mac_sequencer.
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  localparam int NT = NUM_TAP_DEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_mac_sequencer_if #(
    .DATA_WIDTH(DATA_WIDTH_DEF), .WIDTH(WIDTH_DEF),
    .OUT_WIDTH(OUT_WIDTH_DEF), .ADDR_WIDTH(ADDR_WIDTH_DEF)
  ) bus ();

  fir_mac_sequencer dut (
    .iClk12M(clk),
    .iRst   (rst),
    .bus    (bus)
  );

  // Synchronous coefficient memory
  logic signed [WIDTH_DEF-1:0] mem [64];
  always @(posedge clk) bus.iCoeffData <= mem[bus.oCoeffAddr];

  // MAC unit: single accumulator register, load on oEnAdd, accumulate on oEnAcc
  logic signed [OUT_WIDTH_DEF-1:0] dx, cx, prod, acc;
  assign dx   = bus.oDelay;
  assign cx   = bus.oCoeff;
  assign prod = bus.oEnMul ? dx * cx : '0;
  always @(posedge clk or posedge rst) begin
    if (rst)             acc <= '0;
    else if (bus.oEnAdd) acc <= prod;
    else if (bus.oEnAcc) acc <= acc + prod;
  end
  assign bus.iMac = acc;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint sat(input longint v);
`ifdef FIR_OUT_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
`endif
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.iEnSample = 1'b0;
    bus.iFirIn = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Presents a sample for one cycle; returns at the following negedge (cycle 1)
  task automatic send(input logic signed [DATA_WIDTH_DEF-1:0] x);
    bus.iEnSample = 1'b1;
    bus.iFirIn = x;
    @(negedge clk);
    bus.iEnSample = 1'b0;
    bus.iFirIn = '0;
  endtask

  // Called at cycle 1 of a sequence; returns the cycle number where oFirValid was seen
  task automatic wait_valid(input string nm, output int cyc);
    cyc = 1;
    while (!bus.oFirValid && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    chk({nm, "_valid"}, longint'(bus.oFirValid), 1);
  endtask

  task automatic set_coeffs_ramp();
    for (int k = 0; k < 64; k++) mem[k] = (k < NT) ? WIDTH_DEF'(k + 1) : '0;
  endtask

  typedef struct {
    logic signed [DATA_WIDTH_DEF-1:0] x;
    logic signed [WIDTH_DEF-1:0]      c0;
    longint                           exp_raw;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, e_mul, e_add, e_acc, e_addr, e_dly, nvalid;
    longint outv;

    vecs[0] = '{x: -3'sd4, c0: -16'sd100,   exp_raw: 400};
    vecs[1] = '{x: -3'sd4, c0: 16'sd100,    exp_raw: -400};
    vecs[2] = '{x: 3'sd3,  c0: 16'sd1000,   exp_raw: 3000};
    vecs[3] = '{x: -3'sd1, c0: 16'sd32767,  exp_raw: -32767};
    vecs[4] = '{x: 3'sd3,  c0: -16'sd32768, exp_raw: -98304};
    vecs[5] = '{x: -3'sd4, c0: -16'sd32768, exp_raw: 131072};

    for (int k = 0; k < 64; k++) mem[k] = '0;
    rst = 1'b1;
    bus.iEnSample = 1'b0;
    bus.iFirIn = '0;
    @(negedge clk);
    chk("rst_busy",    longint'(bus.oBusy), 0);
    chk("rst_valid",   longint'(bus.oFirValid), 0);
    chk("rst_out",     longint'(bus.oFirOut), 0);
    chk("rst_overrun", longint'(bus.oOverrun), 0);
    chk("rst_addr",    longint'(bus.oCoeffAddr), 0);
    chk("rst_mul",     longint'(bus.oEnMul), 0);

    // Single-sample vectors: output = x * coeff[0], others zero
    foreach (vecs[i]) begin
      for (int k = 0; k < 64; k++) mem[k] = '0;
      mem[0] = vecs[i].c0;
      do_reset();
      send(vecs[i].x);
      wait_valid($sformatf("vec%0d", i), cyc);
      chk($sformatf("vec%0d_latency", i), longint'(cyc), 43);
      chk($sformatf("vec%0d_out", i), longint'(bus.oFirOut), sat(vecs[i].exp_raw));
      @(negedge clk);
      chk($sformatf("vec%0d_valid_drop", i), longint'(bus.oFirValid), 0);
      chk($sformatf("vec%0d_idle", i), longint'(bus.oBusy), 0);
    end

    // Enable / address timing, sample +1 at cycle 0
    set_coeffs_ramp();
    do_reset();
    send(3'sd1);
    chk("fetch_addr", longint'(bus.oCoeffAddr), 0);
    chk("fetch_mul",  longint'(bus.oEnMul), 0);
    chk("fetch_busy", longint'(bus.oBusy), 1);
    e_mul = 0; e_add = 0; e_acc = 0; e_addr = 0; e_dly = 0;
    for (int c = 2; c <= 41; c++) begin
      @(negedge clk);
      if (bus.oEnMul !== 1'b1) e_mul++;
      if (bus.oEnAdd !== (c == 2)) e_add++;
      if (bus.oEnAcc !== (c != 2)) e_acc++;
      if (int'(bus.oCoeffAddr) != c - 1) e_addr++;
      if (int'(bus.oDelay) != ((c == 2) ? 1 : 0)) e_dly++;
    end
    chk("mac_mul_errs",  e_mul, 0);
    chk("mac_add_errs",  e_add, 0);
    chk("mac_acc_errs",  e_acc, 0);
    chk("mac_addr_errs", e_addr, 0);
    chk("mac_dly_errs",  e_dly, 0);
    @(negedge clk);
    chk("cap_mul",   longint'(bus.oEnMul), 0);
    chk("cap_busy",  longint'(bus.oBusy), 1);
    chk("cap_valid", longint'(bus.oFirValid), 0);
    chk("cap_delay", longint'(bus.oDelay), 0);
    @(negedge clk);
    chk("c43_valid", longint'(bus.oFirValid), 1);
    chk("c43_out",   longint'(bus.oFirOut), 1);
    @(negedge clk);
    chk("c44_valid", longint'(bus.oFirValid), 0);
    chk("c44_busy",  longint'(bus.oBusy), 0);

    // Impulse response: next sample issued in each oFirValid cycle
    do_reset();
    send(3'sd1);
    for (int n = 1; n <= NT + 1; n++) begin
      wait_valid($sformatf("imp%0d", n), cyc);
      chk($sformatf("imp%0d_out", n), longint'(bus.oFirOut), (n <= NT) ? n : 0);
      if (n <= NT) send(3'sd0);
    end
    chk("imp_overrun", longint'(bus.oOverrun), 0);

    // All coefficients 1000, forty samples of +3
    for (int k = 0; k < 64; k++) mem[k] = 16'sd1000;
    do_reset();
    send(3'sd3);
    for (int n = 1; n <= NT; n++) begin
      wait_valid($sformatf("dc%0d", n), cyc);
      outv = longint'(bus.oFirOut);
      if (n == 1)  chk("dc1_out",  outv, 3000);
      if (n == 11) chk("dc11_out", outv, sat(33000));
      if (n == NT) chk("dc40_out", outv, sat(120000));
      if (n < NT) send(3'sd3);
    end

    // Overrun during MAC: second sample 5 cycles after the first is dropped
    for (int k = 0; k < 64; k++) mem[k] = '0;
    mem[0] = 16'sd100;
    mem[1] = 16'sd10;
    do_reset();
    send(3'sd3);
    repeat (4) @(negedge clk);
    send(-3'sd4);
    chk("ovr_flag", longint'(bus.oOverrun), 1);
    wait_valid("ovr1", cyc);
    chk("ovr1_out", longint'(bus.oFirOut), 300);
    send(3'sd1);
    wait_valid("ovr2", cyc);
    chk("ovr2_out", longint'(bus.oFirOut), 130);
    chk("ovr_sticky", longint'(bus.oOverrun), 1);

    // Overrun during CAPTURE
    do_reset();
    chk("ovr_cleared", longint'(bus.oOverrun), 0);
    send(3'sd1);
    repeat (41) @(negedge clk);
    chk("capovr_state", longint'({bus.oBusy, bus.oEnMul}), 2);
    send(-3'sd4);
    chk("capovr_valid", longint'(bus.oFirValid), 1);
    chk("capovr_out", longint'(bus.oFirOut), 100);
    chk("capovr_flag", longint'(bus.oOverrun), 1);

    // Reset at tap 10 after a completed output
    set_coeffs_ramp();
    do_reset();
    send(3'sd1);
    wait_valid("rm_pre", cyc);
    chk("rm_pre_out", longint'(bus.oFirOut), 1);
    send(3'sd2);
    repeat (11) @(negedge clk);
    chk("rm_tap10_mul",  longint'(bus.oEnMul), 1);
    chk("rm_tap10_addr", longint'(bus.oCoeffAddr), 11);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_mul",   longint'(bus.oEnMul), 0);
    chk("rm_busy",  longint'(bus.oBusy), 0);
    chk("rm_valid", longint'(bus.oFirValid), 0);
    chk("rm_out",   longint'(bus.oFirOut), 0);
    nvalid = 0;
    repeat (45) begin
      @(negedge clk);
      if (bus.oFirValid) nvalid++;
    end
    chk("rm_no_partial", nvalid, 0);
    send(3'sd3);
    wait_valid("rm_post", cyc);
    chk("rm_post_latency", longint'(cyc), 43);
    chk("rm_post_out", longint'(bus.oFirOut), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
